// File: rtl/inst_queue.sv
// In-order fetch-to-decode instruction queue: DEPTH-entry ring of {pc, word}; head is shown at o_* one cycle after enqueue.
// Backpressure via o_ready (registered full); i_flush empties it. Optional same-cycle empty bypass: INST_QUEUE_BYPASS_EN.
module inst_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [ADDR_WIDTH-1:0]   i_pc,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic                    o_ready,
    input  logic                    i_stall,
    input  logic                    i_flush,
    output logic                    o_valid,
    output logic [ADDR_WIDTH-1:0]   o_pc,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL  = DEPTH[PW:0];
    localparam logic [PW:0]   ONE_C = 1;
    localparam logic [PW-1:0] ONE_P = 1;

    logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] dat_mem [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          empty, bypass, enq, wr, deq;

    assign empty   = (count_q == '0);
    assign o_ready = (count_q != FULL);
    assign o_count = count_q;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = empty && i_valid && !i_flush && !i_stall;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed by decode directly and never occupies a slot.
    assign enq = i_valid && o_ready;
    assign wr  = enq && !bypass && !i_flush;
    assign deq = !empty && !i_stall && !i_flush;

    always_comb begin
        o_valid = !empty || bypass;
        o_pc    = '0;
        o_data  = '0;
        if (!empty) begin
            o_pc   = pc_mem[head_q];
            o_data = dat_mem[head_q];
        end else if (bypass) begin
            o_pc   = i_pc;
            o_data = i_data;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr)
                tail_d = tail_q + ONE_P;
            if (deq)
                head_d = head_q + ONE_P;
            if (wr && !deq)
                count_d = count_q + ONE_C;
            else if (deq && !wr)
                count_d = count_q - ONE_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[tail_q]  <= i_pc;
            dat_mem[tail_q] <= i_data;
        end
    end

`ifdef SIMULATION
    a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= FULL);
    a_empty_ptr: assert property (@(posedge clk) disable iff (rst) (count_q == '0) |-> (head_q == tail_q));
`endif
endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_inst_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_stall, i_flush;
    logic [31:0] i_pc, i_data;
    logic        o_ready, o_valid;
    logic [31:0] o_pc, o_data;
    logic [2:0]  o_count;

    int total = 0;
    int bad   = 0;
    logic [63:0] mq[$];   // reference contents, {pc, data}, oldest first

    inst_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_pc(i_pc), .i_data(i_data), .o_ready(o_ready),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_valid(o_valid), .o_pc(o_pc), .o_data(o_data), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Entered at posedge+1: drive, check outputs at posedge+4, advance model, leave at next posedge+1.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] dat,
                        input logic st, input logic fl, output logic acc);
        logic        byp;
        logic [63:0] hd;
        i_valid = v; i_pc = pc; i_data = dat; i_stall = st; i_flush = fl;
        #3;
`ifdef INST_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && v && !fl && !st;
`else
        byp = 1'b0;
`endif
        hd = (mq.size() != 0) ? mq[0] : (byp ? {pc, dat} : 64'd0);
        check("valid", o_valid, (mq.size() != 0) || byp);
        check("pc",    o_pc,    hd[63:32]);
        check("data",  o_data,  hd[31:0]);
        check("ready", o_ready, mq.size() != 4);
        check("count", o_count, mq.size());
        acc = v && (mq.size() != 4);
        if (fl) mq.delete();
        else begin
            if (mq.size() != 0 && !st) void'(mq.pop_front());
            if (acc && !byp) mq.push_back({pc, dat});
        end
        @(posedge clk); #1;
    endtask

    // Fetch holds the word until accepted; an expired budget is a failed comparison.
    task automatic push(input logic [31:0] pc, input logic [31:0] dat, input logic st);
        logic acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) step(1'b1, pc, dat, st, 1'b0, acc);
        check("push_timeout", acc, 1'b1);
    endtask

    task automatic drain();
        logic acc;
        for (int n = 0; n < 20 && mq.size() != 0; n++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
        check("drain_empty", mq.size(), 0);
    endtask

    initial begin
        logic        acc;
        logic        pend;
        logic [31:0] cpc, cdat;
        int          spct;
        rst = 1'b1; i_valid = 1'b0; i_pc = '0; i_data = '0; i_stall = 1'b0; i_flush = 1'b0;
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_count", o_count, 3'd0);
        @(posedge clk); #1; rst = 1'b0;

        // In-order stream
        push(32'h100, 32'h20080001, 1'b0);
        push(32'h104, 32'h20090002, 1'b0);
        push(32'h108, 32'h01095020, 1'b0);
        drain();

        // Full / backpressure: 4 accepted under stall, 5th held then accepted after release
        for (int k = 0; k < 4; k++) push(32'h100 + 32'(4*k), 32'hA000 + 32'(k), 1'b1);
        step(1'b1, 32'h110, 32'hA004, 1'b1, 1'b0, acc);
        check("full_refuse", acc, 1'b0);
        push(32'h110, 32'hA004, 1'b0);
        drain();

        // Simultaneous enq/deq at count=2, across pointer wrap
        push(32'h500, 32'hB000, 1'b1);
        push(32'h504, 32'hB001, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'h508 + 32'(4*k), 32'hB002 + 32'(k), 1'b0, 1'b0, acc);
            check("wrap_acc", acc, 1'b1);
        end
        drain();

        // Flush with concurrent enqueue at count=3
        for (int k = 0; k < 3; k++) push(32'h1F0 + 32'(4*k), 32'hC000 + 32'(k), 1'b1);
        step(1'b1, 32'h200, 32'hDEAD, 1'b0, 1'b1, acc);
        push(32'h300, 32'hC300, 1'b0);
        drain();

        // Empty-queue arrival with and without stall
        push(32'h400, 32'hE400, 1'b0);
        drain();
        push(32'h400, 32'hE401, 1'b1);
        drain();

        // Random traffic in phases of increasing stall pressure
        pend = 1'b0; cpc = 32'h1000; cdat = '0;
        for (int ph = 0; ph < 3; ph++) begin
            spct = (ph == 0) ? 10 : (ph == 1) ? 50 : 85;
            for (int c = 0; c < 300; c++) begin
                logic fl;
                if (!pend && $urandom_range(99) < 70) begin
                    pend = 1'b1; cpc = cpc + 32'd4; cdat = $urandom;
                end
                fl = ($urandom_range(99) < 4);
                step(pend, pend ? cpc : 32'd0, pend ? cdat : 32'd0,
                     $urandom_range(99) < spct, fl, acc);
                if (acc || fl) pend = 1'b0;
            end
        end
        drain();

        // Reset mid-operation
        for (int k = 0; k < 3; k++) push(32'h700 + 32'(4*k), 32'hF000 + 32'(k), 1'b1);
        i_valid = 1'b0; i_stall = 1'b0;
        #2; rst = 1'b1; #1;
        check("mrst_valid", o_valid, 1'b0);
        check("mrst_count", o_count, 3'd0);
        check("mrst_ready", o_ready, 1'b1);
        check("mrst_data",  o_data,  32'd0);
        mq.delete();
        @(posedge clk); #1; rst = 1'b0;
        push(32'h800, 32'h12345678, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
